// File: rtl/interp_pkg.sv
// Constants and sample type shared by the input selector, sample buffer and interpolation datapath.
package interp_pkg;
    localparam int SAMPLE_W      = 14;
    localparam int TAP_N         = 4;
    localparam int DEFAULT_DEPTH = 8;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/interp_buffer_ctrl.sv
// Pointer, occupancy and flag control for the interpolator sample ring.
// Optional sticky dropped-write flag enabled by INTERP_SAMPLE_BUFFER_OVF_EN.
module interp_buffer_ctrl
    import interp_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_wr_en,
    input  logic             i_rd_adv,
    output logic             o_mem_we,
    output logic [PTR_W-1:0] o_wr_ptr,
    output logic [PTR_W-1:0] o_rd_ptr,
    output logic             o_window_valid,
    output logic             o_full,
    output logic             o_empty
`ifdef INTERP_SAMPLE_BUFFER_OVF_EN
    ,
    output logic             o_overflow
`endif
);
    localparam logic [CNT_W-1:0] TAP_CNT   = CNT_W'(TAP_N);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_adv_ok;
    logic             w_wr_ok;

    assign w_adv_ok = i_rd_adv && (r_count >= TAP_CNT);
    // When full, a simultaneous advance frees the slot WR_PTR points at.
    assign w_wr_ok  = i_wr_en && ((r_count < DEPTH_CNT) || w_adv_ok);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_adv_ok)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr_ok && !w_adv_ok)
                r_count <= r_count + 1'b1;
            else if (w_adv_ok && !w_wr_ok)
                r_count <= r_count - 1'b1;
        end
    end

`ifdef INTERP_SAMPLE_BUFFER_OVF_EN
    logic r_overflow;

    // Survives CLEAR so software can see a drop that preceded a flush.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_overflow <= 1'b0;
        else if (i_wr_en && !w_wr_ok && !i_clear)
            r_overflow <= 1'b1;
    end

    assign o_overflow = r_overflow;
`endif

    assign o_mem_we       = w_wr_ok && !i_clear;
    assign o_wr_ptr       = r_wr_ptr;
    assign o_rd_ptr       = r_rd_ptr;
    assign o_window_valid = (r_count >= TAP_CNT);
    assign o_full         = (r_count == DEPTH_CNT);
    assign o_empty        = (r_count == '0);
endmodule

// File: rtl/interp_sample_buffer.sv
// Circular sample store presenting a TAP_N-sample sliding window to the interpolator.
// Optional o_overflow port enabled by INTERP_SAMPLE_BUFFER_OVF_EN.
module interp_sample_buffer
    import interp_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_clear,
    input  logic                i_wr_en,
    input  logic [SAMPLE_W-1:0] i_data_in,
    input  logic                i_rd_adv,
    output logic [SAMPLE_W-1:0] o_tap_0,
    output logic [SAMPLE_W-1:0] o_tap_1,
    output logic [SAMPLE_W-1:0] o_tap_2,
    output logic [SAMPLE_W-1:0] o_tap_3,
    output logic                o_window_valid,
    output logic                o_full,
    output logic                o_empty
`ifdef INTERP_SAMPLE_BUFFER_OVF_EN
    ,
    output logic                o_overflow
`endif
);
    logic             w_mem_we;
    logic [PTR_W-1:0] w_wr_ptr;
    logic [PTR_W-1:0] w_rd_ptr;
    sample_t          r_mem [DEPTH];
    sample_t          w_tap [TAP_N];

    interp_buffer_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_clear        (i_clear),
        .i_wr_en        (i_wr_en),
        .i_rd_adv       (i_rd_adv),
        .o_mem_we       (w_mem_we),
        .o_wr_ptr       (w_wr_ptr),
        .o_rd_ptr       (w_rd_ptr),
        .o_window_valid (o_window_valid),
        .o_full         (o_full),
        .o_empty        (o_empty)
`ifdef INTERP_SAMPLE_BUFFER_OVF_EN
        ,
        .o_overflow     (o_overflow)
`endif
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_mem_we) begin
            r_mem[w_wr_ptr] <= sample_t'(i_data_in);
        end
    end

    // Taps are read straight from registered state; index wraps with the pointer width.
    for (genvar k = 0; k < TAP_N; k++) begin : g_tap
        assign w_tap[k] = r_mem[w_rd_ptr + PTR_W'(k)];
    end

    assign o_tap_0 = w_tap[0];
    assign o_tap_1 = w_tap[1];
    assign o_tap_2 = w_tap[2];
    assign o_tap_3 = w_tap[3];
endmodule

// File: tb/tb_interp_sample_buffer.sv
// Directed self-checking bench for interp_sample_buffer with a queue reference for the wrap sequence.
module tb_interp_sample_buffer;
    import interp_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                clear = 1'b0;
    logic                wr_en = 1'b0;
    logic [SAMPLE_W-1:0] data_in = '0;
    logic                rd_adv = 1'b0;
    logic [SAMPLE_W-1:0] tap_0, tap_1, tap_2, tap_3;
    logic                window_valid, full, empty;
`ifdef INTERP_SAMPLE_BUFFER_OVF_EN
    logic                overflow;
`endif

    int checks = 0;
    int failures = 0;
    int q[$];

    interp_sample_buffer #(.DEPTH(8)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_clear        (clear),
        .i_wr_en        (wr_en),
        .i_data_in      (data_in),
        .i_rd_adv       (rd_adv),
        .o_tap_0        (tap_0),
        .o_tap_1        (tap_1),
        .o_tap_2        (tap_2),
        .o_tap_3        (tap_3),
        .o_window_valid (window_valid),
        .o_full         (full),
        .o_empty        (empty)
`ifdef INTERP_SAMPLE_BUFFER_OVF_EN
        ,
        .o_overflow     (overflow)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [SAMPLE_W-1:0] s(input int v);
        return v[SAMPLE_W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [SAMPLE_W-1:0] obs, input logic [SAMPLE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic chk_win(input string tag, input int a, input int b, input int c, input int d);
        chk({tag, "_t0"}, tap_0, s(a));
        chk({tag, "_t1"}, tap_1, s(b));
        chk({tag, "_t2"}, tap_2, s(c));
        chk({tag, "_t3"}, tap_3, s(d));
    endtask

    task automatic chk_flags(input string tag, input logic v, input logic f, input logic e);
        chk({tag, "_valid"}, {13'd0, window_valid}, {13'd0, v});
        chk({tag, "_full"},  {13'd0, full},         {13'd0, f});
        chk({tag, "_empty"}, {13'd0, empty},        {13'd0, e});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit we, input int v, input bit adv, input bit clr);
        wr_en   = we;
        data_in = s(v);
        rd_adv  = adv;
        clear   = clr;
        tick();
        wr_en  = 1'b0;
        rd_adv = 1'b0;
        clear  = 1'b0;
    endtask

    initial begin
        int vals[13] = '{-8192, 8191, 1, -1, 100, -100, 2000, -2000, 8191, -8192, 7, 0, 42};

        // Reset state
        #12;
        chk_flags("rst", 1'b0, 1'b0, 1'b1);
        chk_win("rst", 0, 0, 0, 0);
`ifdef INTERP_SAMPLE_BUFFER_OVF_EN
        chk("rst_ovf", {13'd0, overflow}, 14'd0);
`endif
        rst = 1'b0;

        // First window
        step(1, 1, 0, 0);
        step(1, 2, 0, 0);
        step(1, 3, 0, 0);
        chk_flags("w3", 1'b0, 1'b0, 1'b0);
        step(1, -4, 0, 0);
        chk_flags("w4", 1'b1, 1'b0, 1'b0);
        chk_win("w4", 1, 2, 3, -4);

        // Write and advance together keeps the count at 4
        step(1, 5, 1, 0);
        chk_flags("wradv", 1'b1, 1'b0, 1'b0);
        chk_win("wradv", 2, 3, -4, 5);

        // Flush, then fill to full
        step(0, 0, 0, 1);
        chk_flags("clr0", 1'b0, 1'b0, 1'b1);
        step(0, 0, 1, 0);
        chk_flags("advempty", 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1, 10 + i, 0, 0);
        chk_flags("fill", 1'b1, 1'b1, 1'b0);
        chk_win("fill", 10, 11, 12, 13);

        // Dropped write when full
        step(1, 99, 0, 0);
        chk_flags("drop", 1'b1, 1'b1, 1'b0);
        chk_win("drop", 10, 11, 12, 13);
`ifdef INTERP_SAMPLE_BUFFER_OVF_EN
        chk("drop_ovf", {13'd0, overflow}, 14'd1);
`endif

        // Full with simultaneous advance: write lands in freed slot 0
        step(1, 99, 1, 0);
        chk_flags("fulladv", 1'b1, 1'b1, 1'b0);
        chk_win("fulladv", 11, 12, 13, 14);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        chk_flags("adv4", 1'b1, 1'b0, 1'b0);
        chk_win("adv4", 15, 16, 17, 99);

        // COUNT=5, then CLEAR with write and advance: nothing written, memory kept
        step(1, 50, 0, 0);
        step(1, 777, 1, 1);
        chk_flags("clr5", 1'b0, 1'b0, 1'b1);
        chk_win("clr5", 99, 50, 12, 13);
`ifdef INTERP_SAMPLE_BUFFER_OVF_EN
        chk("clr_ovf", {13'd0, overflow}, 14'd1);
`endif

        // Wrap sequence against a queue reference
        q.delete();
        for (int i = 0; i < 13; i++) begin
            bit adv;
            bit adv_ok;
            bit wr_ok;
            adv    = (i >= 4) && (i != 8);
            adv_ok = adv && (q.size() >= 4);
            wr_ok  = (q.size() < 8) || adv_ok;
            if (adv_ok) void'(q.pop_front());
            if (wr_ok) q.push_back(vals[i]);
            step(1, vals[i], adv, 0);
            chk("wrap_valid", {13'd0, window_valid}, {13'd0, q.size() >= 4});
            if (q.size() >= 4) chk_win("wrap", q[0], q[1], q[2], q[3]);
        end
        for (int i = 0; i < 3; i++) begin
            if (q.size() >= 4) void'(q.pop_front());
            step(0, 0, 1, 0);
            chk("wrapadv_valid", {13'd0, window_valid}, {13'd0, q.size() >= 4});
            if (q.size() >= 4) chk_win("wrapadv", q[0], q[1], q[2], q[3]);
        end

        // Asynchronous reset while full
        step(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 200 + i, 0, 0);
        chk_flags("prefull", 1'b1, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_flags("arst", 1'b0, 1'b0, 1'b1);
        chk_win("arst", 0, 0, 0, 0);
`ifdef INTERP_SAMPLE_BUFFER_OVF_EN
        chk("arst_ovf", {13'd0, overflow}, 14'd0);
`endif
        #3;
        rst = 1'b0;
        step(1, 123, 0, 0);
        chk_flags("post", 1'b0, 1'b0, 1'b0);
        chk_win("post", 123, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/interp_sample_buffer.md
Name: interp_sample_buffer

Overview:
- Circular sample buffer directly downstream of the interpolation/external-sample input selector.
- Stores the 14-bit signed samples chosen by the selector, one sample per write strobe.
- Presents a sliding window of TAP_N consecutive samples to the interpolation datapath.
- The interpolator consumes the window one sample at a time by advancing the read pointer.

Parameters:
- DEPTH, 8, number of sample slots; power of two, DEPTH >= TAP_N.
- TAP_N, 4, number of consecutive samples presented as the window.
- SAMPLE_W, 14, sample width in bits, two's complement.

Ports:
- CLK  input  1  single clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- CLEAR  input  1  synchronous flush of pointers and count.
- WR_EN  input  1  write strobe for DATA_IN.
- DATA_IN  input  SAMPLE_W  signed sample from the selector output.
- RD_ADV  input  1  interpolator request to drop the oldest sample.
- TAP_0..TAP_3  output  SAMPLE_W each  signed window; TAP_0 is the oldest sample; count follows TAP_N.
- WINDOW_VALID  output  1  high when COUNT >= TAP_N.
- FULL  output  1  high when COUNT == DEPTH.
- EMPTY  output  1  high when COUNT == 0.
- OVERFLOW  output  1  sticky dropped-write flag; present only with the optional feature.

Behaviour:
- State: MEM[0..DEPTH-1], WR_PTR, RD_PTR (log2(DEPTH) bits each, wrap modulo DEPTH), COUNT (0..DEPTH).
- Reset (RST high, asynchronous): MEM, WR_PTR, RD_PTR and COUNT are 0. Outputs: TAP_k=0, WINDOW_VALID=0, FULL=0, EMPTY=1, OVERFLOW=0.
- Reset asserted mid-operation aborts everything immediately. No partial write survives.
- CLEAR (synchronous) sets WR_PTR, RD_PTR and COUNT to 0. MEM is retained. CLEAR has priority over WR_EN and RD_ADV in the same cycle. CLEAR does not clear OVERFLOW.
- Advance accepted (adv_ok) = RD_ADV && COUNT >= TAP_N. Each accepted advance moves RD_PTR +1 and discards exactly one sample.
- RD_ADV while WINDOW_VALID=0 is ignored with no state change.
- Write accepted (wr_ok) = WR_EN && (COUNT < DEPTH || adv_ok). On wr_ok: MEM[WR_PTR] <= DATA_IN, then WR_PTR +1.
- COUNT update:
  - wr_ok only: +1.
  - adv_ok only: -1.
  - both, or neither: unchanged.
- Full with a simultaneous advance: both operations are accepted. The write goes to the slot being freed, because WR_PTR == RD_PTR when full.
- WR_EN while full without an advance: the sample is dropped and all state is unchanged.
- TAP_k = MEM[(RD_PTR+k) mod DEPTH]. This is a combinational read of registered state, so there are no combinational input-to-output paths.
- A write accepted at edge n is visible on the taps and flags in the cycle after edge n (latency 1).
- WINDOW_VALID, FULL and EMPTY are decoded from the registered COUNT.
- TAP values are don't-care when WINDOW_VALID=0, but deterministic: stale or reset contents.
- Data passes through unmodified; no arithmetic and no saturation on samples.

Optional Feature:
- Macro: INTERP_SAMPLE_BUFFER_OVF_EN.
- Defined: OVERFLOW port exists. It sets on any cycle with WR_EN && !wr_ok && !CLEAR, and stays high until RST.
- Undefined: OVERFLOW port and its flop are absent. Dropped writes are silent. All other behaviour is identical.

Decomposition:
- Shared package/include interp_pkg:
  - SAMPLE_W=14
  - TAP_N=4
  - default DEPTH=8
  - a sample_t signed [SAMPLE_W-1:0] typedef, or localparam-sized declarations.
- These constants are shared with the input selector and the interpolation datapath.
- One natural sub-module, interp_buffer_ctrl: pointers, COUNT, wr_ok/adv_ok, flags and OVERFLOW.
- The top level holds MEM and the tap read muxes.

Test Plan:
- Reset then write 1,2,3 (3 cycles) -> WINDOW_VALID=0, EMPTY=0. A 4th write of -4 -> next cycle WINDOW_VALID=1 and TAP_0..3 = 1,2,3,-4.
- With taps 1,2,3,-4, write 5 and pulse RD_ADV in the same cycle -> COUNT stays 4, taps = 2,3,-4,5.
- Fill 8 samples 10..17 -> FULL=1. Write 99 with no advance -> dropped, taps still 10..13, OVERFLOW=1 if the macro is defined. Then write 99 with RD_ADV -> taps = 11,12,13,14 and slot 0 holds 99, so the window reaches 99 after 4 more advances.
- Write 13 samples with interleaved advances so the pointers wrap past DEPTH-1 -> taps always equal a reference-model window across the wrap; values include -8192 and 8191 unchanged.
- CLEAR asserted together with WR_EN and RD_ADV while COUNT=5 -> next cycle COUNT=0, EMPTY=1, WINDOW_VALID=0, nothing written.
- RST asserted asynchronously mid-cycle while FULL -> outputs return to reset values without a clock edge; the first post-reset write appears at TAP_0 position slot 0.
